// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, parameter record and width helper
// for the parametrised VGA timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } timing_t;

    localparam timing_t VGA_640X480 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33
    };

    localparam timing_t SVGA_800X600 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1, v_sync: 4, v_bp: 23
    };

    function automatic int unsigned cnt_width(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: position, syncs, strobes and frame counter.
// master drives, slave observes.
interface vga_timing_gen_if #(
    parameter int CW  = 10,
    parameter int FCW = 8
);
    import vga_timing_pkg::*;

    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic           h_sync;
    logic           v_sync;
    logic           frame_active;
    logic           pix_stb;
    logic           line_start;
    logic           frame_start;
    logic           vblank_start;
    logic [FCW-1:0] frame_count;

    modport master (
        output x, y, h_sync, v_sync, frame_active,
        output pix_stb, line_start, frame_start,
        output vblank_start, frame_count
    );

    modport slave (
        input x, y, h_sync, v_sync, frame_active,
        input pix_stb, line_start, frame_start,
        input vblank_start, frame_count
    );

endinterface

// File: rtl/vga_timing_gen_pix_tick_div.sv
// Clock-to-pixel divider: one tick every CLK_DIV enabled clocks.
// Phase is held while en is low.
module pix_tick_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int DW = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VESA-style timing generator with pixel divider,
// sync polarity, run enable, frame counter and event strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_640X480.h_active,
    parameter int H_FP     = VGA_640X480.h_fp,
    parameter int H_SYNC   = VGA_640X480.h_sync,
    parameter int H_BP     = VGA_640X480.h_bp,
    parameter int V_ACTIVE = VGA_640X480.v_active,
    parameter int V_FP     = VGA_640X480.v_fp,
    parameter int V_SYNC   = VGA_640X480.v_sync,
    parameter int V_BP     = VGA_640X480.v_bp,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CLK_DIV  = 1,
    parameter int CW       = 10,
    parameter int FCW      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    vga_timing_gen_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX_T = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1
        || H_BP < 1 || V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1
        || V_BP < 1) begin : g_bad_param
        $error("vga_timing_gen: zero timing value or CLK_DIV < 1");
    end

    if ((64'd1 << CW) <= 64'(MAX_T - 1)) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for timing totals");
    end

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic HS_ON = 1'(H_POL);
    localparam logic VS_ON = 1'(V_POL);

    logic tick;

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    logic           started;
    logic [CW-1:0]  x_q, y_q;
    logic [FCW-1:0] fc_q;
    logic hs_q, vs_q, fa_q, ps_q, ls_q, fs_q, vb_q;

    logic [CW-1:0]  nx, ny;
    logic [FCW-1:0] nfc;
    logic n_ls, n_fs, n_vb, n_fa, n_hs, n_vs;

    // Next position; the first tick after reset presents (0,0).
    always_comb begin
        nx   = x_q;
        ny   = y_q;
        nfc  = fc_q;
        n_ls = 1'b0;
        n_fs = 1'b0;
        unique case (1'b1)
            !started: begin
                nx   = '0;
                ny   = '0;
                n_ls = 1'b1;
                n_fs = 1'b1;
            end
            started && (x_q != H_LAST): begin
                nx = x_q + 1'b1;
            end
            started && (x_q == H_LAST): begin
                nx   = '0;
                n_ls = 1'b1;
                if (y_q != V_LAST) begin
                    ny = y_q + 1'b1;
                end else begin
                    ny   = '0;
                    n_fs = 1'b1;
                    nfc  = fc_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        n_fa = (nx < H_ACT) && (ny < V_ACT);
        n_vb = (nx == '0) && (ny == V_ACT);
        n_hs = ((nx >= HS_BEG) && (nx < HS_END)) ? HS_ON : ~HS_ON;
        n_vs = ((ny >= VS_BEG) && (ny < VS_END)) ? VS_ON : ~VS_ON;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            started <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fc_q    <= '0;
            hs_q    <= ~HS_ON;
            vs_q    <= ~VS_ON;
            fa_q    <= 1'b0;
            ps_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            vb_q    <= 1'b0;
        end else begin
            ps_q <= tick;
            ls_q <= tick && n_ls;
            fs_q <= tick && n_fs;
            vb_q <= tick && n_vb;
            if (tick) begin
                started <= 1'b1;
                x_q     <= nx;
                y_q     <= ny;
                fc_q    <= nfc;
                hs_q    <= n_hs;
                vs_q    <= n_vs;
                fa_q    <= n_fa;
            end
        end
    end

    assign vif.x            = x_q;
    assign vif.y            = y_q;
    assign vif.frame_count  = fc_q;
    assign vif.h_sync       = hs_q;
    assign vif.v_sync       = vs_q;
    assign vif.frame_active = fa_q;
    assign vif.pix_stb      = ps_q;
    assign vif.line_start   = ls_q;
    assign vif.frame_start  = fs_q;
    assign vif.vblank_start = vb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: five timing configurations checked each
// cycle against an arithmetic model, plus directed literal checks.
module tb_vga_timing_gen;

    localparam int N = 5;
    localparam int HA [N] = '{640, 640, 640, 4, 4};
    localparam int HF [N] = '{16, 16, 16, 1, 1};
    localparam int HS [N] = '{96, 96, 96, 2, 2};
    localparam int HB [N] = '{48, 48, 48, 1, 1};
    localparam int VA [N] = '{480, 480, 480, 3, 480};
    localparam int VF [N] = '{10, 10, 10, 1, 10};
    localparam int VS [N] = '{2, 2, 2, 1, 2};
    localparam int VB [N] = '{33, 33, 33, 1, 33};
    localparam int HP [N] = '{0, 0, 0, 1, 0};
    localparam int VP [N] = '{0, 0, 0, 1, 0};
    localparam int DV [N] = '{1, 2, 3, 1, 1};

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic hs, vs, fa, ps, ls, fs, vb;
        logic [7:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic [N-1:0] rst = '1;
    logic [N-1:0] en = '0;
    always #5 clk = ~clk;

    logic [9:0] ox [N];
    logic [9:0] oy [N];
    logic [7:0] ofc [N];
    logic ohs [N], ovs [N], ofa [N], ops [N];
    logic ols [N], ofs [N], ovb [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        vga_timing_gen_if #(.CW(10), .FCW(8)) vif ();
        vga_timing_gen #(
            .H_ACTIVE (HA[g]), .H_FP (HF[g]),
            .H_SYNC (HS[g]), .H_BP (HB[g]),
            .V_ACTIVE (VA[g]), .V_FP (VF[g]),
            .V_SYNC (VS[g]), .V_BP (VB[g]),
            .H_POL (HP[g]), .V_POL (VP[g]),
            .CLK_DIV (DV[g]), .CW (10), .FCW (8)
        ) dut (
            .clk (clk),
            .rst (rst[g]),
            .en  (en[g]),
            .vif (vif)
        );
        assign ox[g]  = vif.x;
        assign oy[g]  = vif.y;
        assign ofc[g] = vif.frame_count;
        assign ohs[g] = vif.h_sync;
        assign ovs[g] = vif.v_sync;
        assign ofa[g] = vif.frame_active;
        assign ops[g] = vif.pix_stb;
        assign ols[g] = vif.line_start;
        assign ofs[g] = vif.frame_start;
        assign ovb[g] = vif.vblank_start;
    end

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Model state: enabled clocks since reset and tick-this-cycle.
    int en_cnt [N];
    bit seen [N];
    bit tk [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst[i]) begin
                en_cnt[i] <= 0;
                seen[i]   <= 1'b1;
                tk[i]     <= 1'b0;
            end else if (en[i]) begin
                en_cnt[i] <= en_cnt[i] + 1;
                tk[i]     <= ((en_cnt[i] + 1) % DV[i]) == 0;
            end else begin
                tk[i] <= 1'b0;
            end
        end
    end

    function automatic obs_t model(int i);
        obs_t o;
        int t, p, ht, vt, xx, yy;
        ht = HA[i] + HF[i] + HS[i] + HB[i];
        vt = VA[i] + VF[i] + VS[i] + VB[i];
        t = en_cnt[i] / DV[i];
        o = '0;
        if (t == 0) begin
            o.hs = (HP[i] == 0);
            o.vs = (VP[i] == 0);
            return o;
        end
        p  = t - 1;
        xx = p % ht;
        yy = (p / ht) % vt;
        o.x  = 10'(xx);
        o.y  = 10'(yy);
        o.fc = 8'((p / (ht * vt)) % 256);
        o.hs = ((xx >= HA[i] + HF[i]) && (xx < HA[i] + HF[i] + HS[i]))
               == (HP[i] != 0);
        o.vs = ((yy >= VA[i] + VF[i]) && (yy < VA[i] + VF[i] + VS[i]))
               == (VP[i] != 0);
        o.fa = (xx < HA[i]) && (yy < VA[i]);
        o.ps = tk[i];
        o.ls = tk[i] && (xx == 0);
        o.fs = tk[i] && (xx == 0) && (yy == 0);
        o.vb = tk[i] && (xx == 0) && (yy == VA[i]);
        return o;
    endfunction

    function automatic obs_t observed(int i);
        obs_t o;
        o.x  = ox[i];
        o.y  = oy[i];
        o.fc = ofc[i];
        o.hs = ohs[i];
        o.vs = ovs[i];
        o.fa = ofa[i];
        o.ps = ops[i];
        o.ls = ols[i];
        o.fs = ofs[i];
        o.vb = ovb[i];
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf(
            "x=%0d y=%0d hs=%0b vs=%0b fa=%0b ps=%0b ls=%0b fs=%0b vb=%0b fc=%0d",
            o.x, o.y, o.hs, o.vs, o.fa, o.ps, o.ls, o.fs, o.vb, o.fc);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (seen[i]) begin
                obs_t a, e;
                a = observed(i);
                e = model(i);
                n_checks++;
                if (a === e) begin
                    n_pass++;
                end else begin
                    n_fail++;
                    if (n_fail <= 20)
                        $display("FAIL model[%0d] t=%0t: got %s, expected %s",
                                 i, $time, fmt(a), fmt(e));
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k, cnt, first_hs, fa_fall, f0;
        int vs_lo, vs_min, vs_max, vb_n, vb_x, vb_y;

        cyc(3);
        rst = '0;
        en  = '1;
        cyc(1);
        chk("t1_x", ox[0], 0);
        chk("t1_y", oy[0], 0);
        chk("t1_frame_active", ofa[0], 1);
        chk("t1_pix_stb", ops[0], 1);
        chk("t1_line_start", ols[0], 1);
        chk("t1_frame_start", ofs[0], 1);
        chk("t1_h_sync", ohs[0], 1);
        chk("t1_v_sync", ovs[0], 1);
        chk("t4_div2_no_tick_yet", ops[1], 0);
        cyc(1);
        chk("t4_div2_first_tick", ops[1], 1);
        chk("t4_div2_first_fs", ofs[1], 1);

        cnt = 0; first_hs = -1; fa_fall = -1; k = 0;
        do begin
            cyc(1);
            k++;
            if (ox[0] != 0) begin
                if (!ohs[0]) begin
                    cnt++;
                    if (first_hs < 0) first_hs = int'(ox[0]);
                end
                if (!ofa[0] && fa_fall < 0) fa_fall = int'(ox[0]);
            end
        end while (ox[0] != 0 && k < 900);
        chk("t2_line_wrap_seen", int'(k < 900), 1);
        chk("t2_hsync_ticks", cnt, 96);
        chk("t2_hsync_first_x", first_hs, 656);
        chk("t2_fa_fall_x", fa_fall, 640);
        chk("t2_next_y", oy[0], 1);
        chk("t2_line_start", ols[0], 1);

        k = 0;
        while (!ols[1] && k < 2000) begin cyc(1); k++; end
        chk("t4_ls_seen", int'(k < 2000), 1);
        k = 0; cnt = 0;
        do begin
            cyc(1);
            k++;
            cnt += int'(ops[1]);
        end while (!ols[1] && k < 2000);
        chk("t4_line_clks", k, 1600);
        chk("t4_line_ticks", cnt, 800);

        k = 0;
        while (!(ops[0] && ox[0] == 100) && k < 900) begin cyc(1); k++; end
        chk("t5_reach_x100", int'(k < 900), 1);
        en[0] = 1'b0;
        repeat (5) begin
            cyc(1);
            chk("t5_hold_x", ox[0], 100);
            chk("t5_hold_ps", ops[0], 0);
        end
        en[0] = 1'b1;
        cyc(1);
        chk("t5_resume_x", ox[0], 101);
        chk("t5_resume_ps", ops[0], 1);

        k = 0;
        while (!(ops[2] && ox[2] == 100) && k < 3000) begin cyc(1); k++; end
        chk("t5_div3_reach_x100", int'(k < 3000), 1);
        cyc(1);
        en[2] = 1'b0;
        repeat (5) begin
            cyc(1);
            chk("t5_div3_hold_x", ox[2], 100);
        end
        en[2] = 1'b1;
        cyc(1);
        chk("t5_div3_phase_ps0", ops[2], 0);
        cyc(1);
        chk("t5_div3_phase_ps1", ops[2], 1);
        chk("t5_div3_x", ox[2], 101);

        k = 0;
        while (!ofs[4] && k < 5000) begin cyc(1); k++; end
        chk("t3_frame_start_seen", int'(k < 5000), 1);
        f0 = int'(ofc[4]);
        vs_lo = 0; vs_min = 9999; vs_max = -1;
        vb_n = 0; vb_x = -1; vb_y = -1;
        for (int j = 1; j <= 4200; j++) begin
            cyc(1);
            if (j < 4200) begin
                if (!ovs[4]) begin
                    vs_lo++;
                    if (int'(oy[4]) < vs_min) vs_min = int'(oy[4]);
                    if (int'(oy[4]) > vs_max) vs_max = int'(oy[4]);
                end
                if (ovb[4]) begin
                    vb_n++;
                    vb_x = int'(ox[4]);
                    vb_y = int'(oy[4]);
                end
            end
        end
        chk("t3_vsync_ticks", vs_lo, 16);
        chk("t3_vsync_first_y", vs_min, 490);
        chk("t3_vsync_last_y", vs_max, 491);
        chk("t3_vblank_count", vb_n, 1);
        chk("t3_vblank_x", vb_x, 0);
        chk("t3_vblank_y", vb_y, 480);
        chk("t3_wrap_fs", ofs[4], 1);
        chk("t3_wrap_x", ox[4], 0);
        chk("t3_wrap_y", oy[4], 0);
        chk("t3_frame_count", ofc[4], (f0 + 1) % 256);

        k = 0;
        while (!(ofs[3] && ofc[3] == 8'd255) && k < 26000) begin
            cyc(1);
            k++;
        end
        chk("t3_fc255_seen", int'(k < 26000), 1);
        k = 0;
        do begin cyc(1); k++; end while (!ofs[3] && k < 100);
        chk("t3_small_frame_len", k, 48);
        chk("t3_fc_wrap", ofc[3], 0);

        k = 0;
        while (!(ops[3] && ox[3] == 5 && oy[3] == 4) && k < 100) begin
            cyc(1);
            k++;
        end
        chk("t6_reach_5_4", int'(k < 100), 1);
        rst[3] = 1'b1;
        cyc(1);
        chk("t6_rst_x", ox[3], 0);
        chk("t6_rst_y", oy[3], 0);
        chk("t6_rst_fa", ofa[3], 0);
        chk("t6_rst_hs", ohs[3], 0);
        chk("t6_rst_vs", ovs[3], 0);
        chk("t6_rst_ps", ops[3], 0);
        chk("t6_rst_fc", ofc[3], 0);
        rst[3] = 1'b0;
        cyc(1);
        chk("t6_restart_fs", ofs[3], 1);
        chk("t6_restart_x", ox[3], 0);
        chk("t6_restart_fa", ofa[3], 1);
        k = 0;
        while (!(ops[3] && ox[3] == 5) && k < 20) begin cyc(1); k++; end
        chk("t6_hs_high", ohs[3], 1);
        k = 0;
        while (!(ops[3] && oy[3] == 4) && k < 100) begin cyc(1); k++; end
        chk("t6_vs_high", ovs[3], 1);

        repeat (3000) begin
            cyc(1);
            for (int i = 0; i < N; i++) begin
                en[i]  = ($urandom_range(3, 0) != 0);
                rst[i] = ($urandom_range(399, 0) == 0);
            end
        end
        rst = '0;
        en  = '1;
        cyc(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
